// File: rtl/dac_pkg.sv
// dac_pkg: shared types and constants for the serial DAC transmitter.
//   state_t      - transmitter FSM states
//   FRAME_BITS   - length of one serial command word
//   DAC_CMD_DEF  - default command nibble ("write and update")
//   MIDSCALE_DEF - default sample replayed before the first handshake
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam int          FRAME_BITS   = 16;
    localparam logic [3:0]  DAC_CMD_DEF  = 4'b0011;
    localparam logic [7:0]  MIDSCALE_DEF = 8'h80;

endpackage

// File: rtl/dac_clk_gen.sv
// dac_clk_gen: free-running divider producing the DAC serial clock.
//   osc_clk   in  system clock
//   rst_n     in  synchronous active-low reset
//   dac_clk   out osc_clk / CLK_DIV, 50% duty, 0 after reset
//   fall_tick out high on the osc_clk cycle whose edge takes dac_clk 1->0
module dac_clk_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic osc_clk,
    input  logic rst_n,
    output logic dac_clk,
    output logic fall_tick
);

    localparam int HALF = CLK_DIV / 2;
    localparam int W    = (HALF > 1) ? $clog2(HALF) : 1;

    logic [W-1:0] div_cnt;
    logic         last;

    assign last = (div_cnt == W'(HALF - 1));
    // Combinational so the FSM registers its updates on the same edge
    // that drops dac_clk.
    assign fall_tick = last && dac_clk;

    always_ff @(posedge osc_clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            dac_clk <= 1'b0;
        end else if (last) begin
            div_cnt <= '0;
            dac_clk <= ~dac_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_com.sv
// dac_com: serial transmitter to an external 12-bit SPI-style DAC.
// Pulls 8-bit samples over ready/valid and sends each as a 16-bit word
// {DAC_CMD, sample, 4'b0000}, MSB first, at a fixed frame rate.
//   osc_clk      in  system clock
//   rst_n        in  synchronous active-low reset
//   enable       in  1 = stream frames; 0 = finish current frame, then idle
//   sample_data  in  sample from buffer
//   sample_valid in  sample_data valid
//   sample_ready out block accepts a sample this cycle
//   dac_clk      out serial clock
//   dac_cs_n     out frame select, active low
//   dac_din      out serial data, changes on dac_clk falling edge
//   busy         out high while dac_cs_n low
//   underrun     out one-cycle pulse when a frame starts with a replayed sample
module dac_com
    import dac_pkg::*;
#(
    parameter int         CLK_DIV    = 16,
    parameter int         GAP_CYCLES = 2,
    parameter logic [3:0] DAC_CMD    = DAC_CMD_DEF,
    parameter logic [7:0] MIDSCALE   = MIDSCALE_DEF
) (
    input  logic       osc_clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] sample_data,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       dac_clk,
    output logic       dac_cs_n,
    output logic       dac_din,
    output logic       busy,
    output logic       underrun
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int BW = $clog2(FRAME_BITS);

    logic                  fall_tick;
    state_t                state;
    logic [GW-1:0]         gap_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [7:0]            next_smp;
    logic                  have_next;
    logic [7:0]            last_smp;

    logic                  take;
    logic                  fresh;
    logic [7:0]            smp;
    logic [FRAME_BITS-1:0] frame;

    dac_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .osc_clk   (osc_clk),
        .rst_n     (rst_n),
        .dac_clk   (dac_clk),
        .fall_tick (fall_tick)
    );

    assign sample_ready = (state == GAP) && enable && !have_next;
    assign take         = sample_valid && sample_ready;

    // A handshake landing on the frame-start edge still counts as fresh.
    assign fresh = take || have_next;
    assign smp   = take ? sample_data : (have_next ? next_smp : last_smp);
    assign frame = {DAC_CMD, smp, 4'b0000};

    always_ff @(posedge osc_clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            next_smp  <= '0;
            have_next <= 1'b0;
            last_smp  <= MIDSCALE;
            dac_cs_n  <= 1'b1;
            dac_din   <= 1'b0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (take) begin
                next_smp  <= sample_data;
                have_next <= 1'b1;
            end
            if (fall_tick) begin
                case (state)
                    IDLE: begin
                        if (enable) begin
                            state   <= GAP;
                            gap_cnt <= GW'(GAP_CYCLES - 1);
                        end
                    end
                    GAP: begin
                        if (gap_cnt != '0) begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end else if (!enable) begin
                            state <= IDLE;
                        end else begin
                            state     <= SHIFT;
                            dac_cs_n  <= 1'b0;
                            busy      <= 1'b1;
                            bit_cnt   <= BW'(FRAME_BITS - 1);
                            dac_din   <= frame[FRAME_BITS-1];
                            shreg     <= {frame[FRAME_BITS-2:0], 1'b0};
                            last_smp  <= smp;
                            // Overrides the take above: that sample is used now.
                            have_next <= 1'b0;
                            underrun  <= !fresh;
                        end
                    end
                    SHIFT: begin
                        if (bit_cnt != '0) begin
                            bit_cnt <= bit_cnt - 1'b1;
                            dac_din <= shreg[FRAME_BITS-1];
                            shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                        end else begin
                            // Bit 0 has been held a full period; close frame.
                            state    <= GAP;
                            dac_cs_n <= 1'b1;
                            busy     <= 1'b0;
                            dac_din  <= 1'b0;
                            gap_cnt  <= GW'(GAP_CYCLES - 1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dac_com.sv
// tb_dac_com: directed bench for dac_com at default parameters.
module tb_dac_com;

    logic       osc_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] sample_data = 8'h00;
    logic       sample_valid = 1'b0;
    logic       sample_ready;
    logic       dac_clk;
    logic       dac_cs_n;
    logic       dac_din;
    logic       busy;
    logic       underrun;

    dac_com dut (
        .osc_clk      (osc_clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .dac_clk      (dac_clk),
        .dac_cs_n     (dac_cs_n),
        .dac_din      (dac_din),
        .busy         (busy),
        .underrun     (underrun)
    );

    always #5 osc_clk = ~osc_clk;

    int tests = 0;
    int fails = 0;

    // ---------------- frame monitor ----------------
    int          cyc = 0;
    logic        prev_clk = 1'b0;
    logic        prev_cs = 1'b1;
    logic [15:0] shreg = '0;
    int          nbits = 0;
    int          frames_started = 0;
    int          frames_done = 0;
    int          fall_cyc = 0;
    logic        start_ur = 1'b0;
    logic        start_busy = 1'b0;
    logic [15:0] last_word = '0;
    int          last_low = 0;
    int          last_nbits = 0;
    int          ur_count = 0;
    int          busy_err = 0;

    always @(posedge osc_clk) begin
        #1;
        cyc++;
        if (underrun === 1'b1) ur_count++;
        if (busy !== !dac_cs_n) busy_err++;
        if (prev_cs && !dac_cs_n) begin
            nbits = 0;
            fall_cyc = cyc;
            start_ur = underrun;
            start_busy = busy;
            frames_started++;
        end
        if (!dac_cs_n && !prev_clk && dac_clk) begin
            shreg = {shreg[14:0], dac_din};
            nbits++;
        end
        if (!prev_cs && dac_cs_n) begin
            last_word = shreg;
            last_low = cyc - fall_cyc;
            last_nbits = nbits;
            frames_done++;
        end
        prev_cs = dac_cs_n;
        prev_clk = dac_clk;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_started(input int tgt, input string nm);
        int n = 0;
        while (frames_started < tgt && n < 2000) begin
            @(posedge osc_clk);
            n++;
        end
        #2;
        chk({nm, "_start_seen"}, 32'(frames_started >= tgt), 32'd1);
    endtask

    task automatic wait_done(input int tgt, input string nm);
        int n = 0;
        while (frames_done < tgt && n < 2000) begin
            @(posedge osc_clk);
            n++;
        end
        #2;
        chk({nm, "_done_seen"}, 32'(frames_done >= tgt), 32'd1);
    endtask

    task automatic offer(input logic [7:0] d, input string nm);
        bit got = 0;
        sample_data = d;
        sample_valid = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge osc_clk);
            if (sample_ready) begin
                @(posedge osc_clk);
                #1;
                sample_valid = 1'b0;
                sample_data = 8'hEE;
                got = 1;
                break;
            end
        end
        sample_valid = 1'b0;
        chk({nm, "_handshake"}, 32'(got), 32'd1);
        chk({nm, "_ready_drop"}, 32'(sample_ready), 32'd0);
    endtask

    task automatic wait_bits(input int tgt, input string nm);
        int n = 0;
        while (nbits < tgt && n < 2000) begin
            @(posedge osc_clk);
            n++;
        end
        #2;
        chk({nm, "_bits_seen"}, 32'(nbits >= tgt), 32'd1);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        do_offer;
        logic [15:0] exp_word;
        logic        exp_ur;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int prev_fall;
        int fs;
        int ur0;
        int rdy_seen;

        vecs[0] = '{8'hA5, 1'b1, 16'h3A50, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 16'h3000, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 16'h3FF0, 1'b0};
        vecs[3] = '{8'h3C, 1'b1, 16'h33C0, 1'b0};
        vecs[4] = '{8'h12, 1'b1, 16'h3120, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 16'h3120, 1'b1};

        // ---- reset state ----
        repeat (5) @(posedge osc_clk);
        #1;
        chk("rst_dac_clk", 32'(dac_clk), 32'd0);
        chk("rst_cs_n", 32'(dac_cs_n), 32'd1);
        chk("rst_din", 32'(dac_din), 32'd0);
        chk("rst_ready", 32'(sample_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);

        // ---- divider: first toggle 8 cycles after release ----
        @(negedge osc_clk);
        rst_n = 1'b1;
        repeat (7) @(posedge osc_clk);
        #1;
        chk("div_pre_toggle", 32'(dac_clk), 32'd0);
        @(posedge osc_clk);
        #1;
        chk("div_first_toggle", 32'(dac_clk), 32'd1);

        // ---- table: single frame, back-to-back, fresh then underrun ----
        enable = 1'b1;
        prev_fall = 0;
        for (int i = 0; i < 6; i++) begin
            fs = frames_started;
            if (vecs[i].do_offer) offer(vecs[i].data, $sformatf("v%0d", i));
            wait_started(fs + 1, $sformatf("v%0d", i));
            chk($sformatf("v%0d_underrun", i), 32'(start_ur), 32'(vecs[i].exp_ur));
            chk($sformatf("v%0d_busy", i), 32'(start_busy), 32'd1);
            if (i > 0) chk($sformatf("v%0d_period", i), 32'(fall_cyc - prev_fall), 32'd288);
            prev_fall = fall_cyc;
            wait_done(fs + 1, $sformatf("v%0d", i));
            chk($sformatf("v%0d_word", i), 32'(last_word), 32'(vecs[i].exp_word));
            chk($sformatf("v%0d_low_len", i), 32'(last_low), 32'd256);
            chk($sformatf("v%0d_nbits", i), 32'(last_nbits), 32'd16);
        end

        // ---- underrun straight from reset: MIDSCALE replayed ----
        @(negedge osc_clk);
        rst_n = 1'b0;
        repeat (5) @(posedge osc_clk);
        @(negedge osc_clk);
        rst_n = 1'b1;
        ur0 = ur_count;
        fs = frames_started;
        wait_started(fs + 1, "mid");
        chk("mid_underrun", 32'(start_ur), 32'd1);
        wait_done(fs + 1, "mid");
        chk("mid_word", 32'(last_word), 32'h3800);
        chk("mid_ur_pulses", 32'(ur_count - ur0), 32'd1);

        // ---- enable dropped at bit 7 ----
        fs = frames_started;
        offer(8'h5A, "endrop");
        wait_started(fs + 1, "endrop");
        wait_bits(8, "endrop");
        enable = 1'b0;
        wait_done(fs + 1, "endrop");
        chk("endrop_word", 32'(last_word), 32'h35A0);
        chk("endrop_nbits", 32'(last_nbits), 32'd16);
        rdy_seen = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge osc_clk);
            if (sample_ready) rdy_seen++;
        end
        chk("endrop_no_frame", 32'(frames_started), 32'(fs + 1));
        chk("endrop_no_ready", 32'(rdy_seen), 32'd0);
        chk("endrop_cs_idle", 32'(dac_cs_n), 32'd1);

        // ---- reset mid-frame at bit 10 ----
        enable = 1'b1;
        fs = frames_started;
        offer(8'h77, "rmid");
        wait_started(fs + 1, "rmid");
        wait_bits(5, "rmid");
        @(negedge osc_clk);
        rst_n = 1'b0;
        @(posedge osc_clk);
        #1;
        chk("rmid_cs_n", 32'(dac_cs_n), 32'd1);
        chk("rmid_din", 32'(dac_din), 32'd0);
        chk("rmid_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge osc_clk);
        @(negedge osc_clk);
        rst_n = 1'b1;
        fs = frames_started;
        wait_started(fs + 1, "rmid_next");
        chk("rmid_next_underrun", 32'(start_ur), 32'd1);
        wait_done(frames_done + 1, "rmid_next");
        chk("rmid_next_word", 32'(last_word), 32'h3800);
        chk("rmid_next_nbits", 32'(last_nbits), 32'd16);

        chk("busy_tracks_cs", 32'(busy_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
